// File: rtl/mine_placer.sv
// Minesweeper board generator: clears an N x N board memory, then places mine_num mines at
// LFSR-chosen distinct fields, never on the protected first-click field.
module mine_placer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned MAX_DIM   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] row_col_num,
  input  logic [7:0] mine_num,
  input  logic [3:0] safe_row,
  input  logic [3:0] safe_col,
  output logic       wr_en,
  output logic [3:0] wr_row,
  output logic [3:0] wr_col,
  output logic       wr_mine,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] placed_ctr
);

  typedef enum logic [2:0] {StIdle, StClear, StGen, StCheck, StWrite, StFin} state_e;

  state_e       state_q, state_d;
  logic [15:0]  lfsr_q, lfsr_d;
  logic [4:0]   n_q, n_d;
  logic [7:0]   mines_q, mines_d;
  logic [3:0]   safe_r_q, safe_r_d, safe_c_q, safe_c_d;
  logic [3:0]   clr_r_q, clr_r_d, clr_c_q, clr_c_d;
  logic [3:0]   cand_r_q, cand_r_d, cand_c_q, cand_c_d;
  logic [255:0] bitmap_q, bitmap_d;
  logic [7:0]   placed_q, placed_d;
  logic         err_q, err_d;

  logic [9:0]   nn;
  logic         settings_ok;
  logic         reject;

  assign nn = {5'd0, row_col_num} * {5'd0, row_col_num};
  assign settings_ok = (row_col_num != 5'd0) && !(32'(row_col_num) > MAX_DIM) &&
                       ({2'd0, mine_num} < nn);

  // Range checks are 5-bit so that N=16 admits index 15.
  assign reject = ({1'b0, cand_r_q} >= n_q) || ({1'b0, cand_c_q} >= n_q) ||
                  bitmap_q[{cand_r_q, cand_c_q}] ||
                  ((cand_r_q == safe_r_q) && (cand_c_q == safe_c_q));

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    n_d      = n_q;
    mines_d  = mines_q;
    safe_r_d = safe_r_q;
    safe_c_d = safe_c_q;
    clr_r_d  = clr_r_q;
    clr_c_d  = clr_c_q;
    cand_r_d = cand_r_q;
    cand_c_d = cand_c_q;
    bitmap_d = bitmap_q;
    placed_d = placed_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d      = row_col_num;
          mines_d  = mine_num;
          safe_r_d = safe_row;
          safe_c_d = safe_col;
          clr_r_d  = 4'd0;
          clr_c_d  = 4'd0;
          placed_d = 8'd0;
          err_d    = !settings_ok;
          state_d  = settings_ok ? StClear : StFin;
        end
      end
      StClear: begin
        bitmap_d = '0;
        if ({1'b0, clr_c_q} == n_q - 5'd1) begin
          clr_c_d = 4'd0;
          clr_r_d = clr_r_q + 4'd1;
          if ({1'b0, clr_r_q} == n_q - 5'd1) begin
            state_d = (mines_q == 8'd0) ? StFin : StGen;
          end
        end else begin
          clr_c_d = clr_c_q + 4'd1;
        end
      end
      StGen: begin
        cand_r_d = lfsr_q[3:0];
        cand_c_d = lfsr_q[7:4];
        state_d  = StCheck;
      end
      StCheck: begin
        state_d = reject ? StGen : StWrite;
      end
      StWrite: begin
        bitmap_d[{cand_r_q, cand_c_q}] = 1'b1;
        placed_d = placed_q + 8'd1;
        state_d  = (placed_q + 8'd1 == mines_q) ? StFin : StGen;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      lfsr_q   <= LFSR_SEED;
      n_q      <= '0;
      mines_q  <= '0;
      safe_r_q <= '0;
      safe_c_q <= '0;
      clr_r_q  <= '0;
      clr_c_q  <= '0;
      cand_r_q <= '0;
      cand_c_q <= '0;
      bitmap_q <= '0;
      placed_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      n_q      <= n_d;
      mines_q  <= mines_d;
      safe_r_q <= safe_r_d;
      safe_c_q <= safe_c_d;
      clr_r_q  <= clr_r_d;
      clr_c_q  <= clr_c_d;
      cand_r_q <= cand_r_d;
      cand_c_q <= cand_c_d;
      bitmap_q <= bitmap_d;
      placed_q <= placed_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    busy       = (state_q == StClear) || (state_q == StGen) ||
                 (state_q == StCheck) || (state_q == StWrite);
    done       = (state_q == StFin);
    err        = err_q;
    placed_ctr = placed_q;
    wr_en      = (state_q == StClear) || (state_q == StWrite);
    wr_mine    = (state_q == StWrite);
    wr_row     = 4'd0;
    wr_col     = 4'd0;
    if (state_q == StClear) begin
      wr_row = clr_r_q;
      wr_col = clr_c_q;
    end else if (state_q == StWrite) begin
      wr_row = cand_r_q;
      wr_col = cand_c_q;
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Randomized bench for mine_placer: a write monitor plus a rule-level board model check
// clear order, mine legality/uniqueness, counts, error handling and LFSR-driven placement.
module tb_mine_placer;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] row_col_num = '0;
  logic [7:0] mine_num = '0;
  logic [3:0] safe_row = '0;
  logic [3:0] safe_col = '0;
  logic       wr_en, wr_mine, busy, done, err;
  logic [3:0] wr_row, wr_col;
  logic [7:0] placed_ctr;

  mine_placer #(.LFSR_SEED(SEED), .MAX_DIM(16)) dut (
    .clk(clk), .rst(rst), .start(start), .row_col_num(row_col_num), .mine_num(mine_num),
    .safe_row(safe_row), .safe_col(safe_col), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_mine(wr_mine), .busy(busy), .done(done), .err(err),
    .placed_ctr(placed_ctr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int clr_wr, mine_wr, done_cnt, viol, done_cyc, start_cyc;
  int cur_n, cur_sr, cur_sc;
  bit seen [256];
  logic [7:0]  first_mine;
  logic [15:0] lfsr_m, lfsr_acc;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Free-running reference LFSR: seed during reset, one step per rising edge after.
  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m = SEED;
    else begin
      lfsr_m = lfsr_step(lfsr_m);
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (wr_en && !busy) viol++;
      if (done && busy) viol++;
      if (wr_en && !wr_mine) begin
        if (mine_wr != 0 || cur_n <= 0 || int'(wr_row) != clr_wr / cur_n ||
            int'(wr_col) != clr_wr % cur_n) viol++;
        clr_wr++;
      end
      if (wr_en && wr_mine) begin
        if (int'(wr_row) >= cur_n || int'(wr_col) >= cur_n ||
            (int'(wr_row) == cur_sr && int'(wr_col) == cur_sc) || seen[{wr_row, wr_col}])
          viol++;
        if (mine_wr == 0) first_mine = {wr_row, wr_col};
        seen[{wr_row, wr_col}] = 1'b1;
        mine_wr++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic pulse_start(input int n, input int m, input int sr, input int sc);
    @(negedge clk);
    clr_wr = 0; mine_wr = 0; done_cnt = 0; viol = 0; first_mine = '0;
    foreach (seen[i]) seen[i] = 1'b0;
    cur_n = n; cur_sr = sr; cur_sc = sc;
    row_col_num = 5'(n); mine_num = 8'(m); safe_row = 4'(sr); safe_col = 4'(sc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    lfsr_acc = lfsr_m;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic recover;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_reset;
    row_col_num = 5'd9; mine_num = 8'd10; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({wr_en, wr_row, wr_col, wr_mine, busy, done, err, placed_ctr} !== 23'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {wr_en, wr_row, wr_col, wr_mine, busy, done, err, placed_ctr});
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({wr_en, busy, done, err, placed_ctr} !== 12'd0) begin
      bad++;
      $display("FAIL idle_after_reset got=%h want=0", {wr_en, busy, done, err, placed_ctr});
    end
  endtask

  task automatic test_board(input int n, input int m, input int sr, input int sc,
                            input int bound);
    bit ok, valid;
    int exp_clr, exp_mines;
    valid     = (n >= 1) && (n <= 16) && (m <= n * n - 1);
    exp_clr   = valid ? n * n : 0;
    exp_mines = valid ? m : 0;
    pulse_start(n, m, sr, sc);
    wait_done(bound, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timeout n=%0d m=%0d got=no_done want=done", n, m);
      recover();
      return;
    end
    total++;
    if (done_cnt !== 1) begin
      bad++; $display("FAIL done_count n=%0d m=%0d got=%0d want=1", n, m, done_cnt);
    end
    total++;
    if (clr_wr !== exp_clr) begin
      bad++; $display("FAIL clear_writes n=%0d got=%0d want=%0d", n, clr_wr, exp_clr);
    end
    total++;
    if (mine_wr !== exp_mines) begin
      bad++; $display("FAIL mine_writes n=%0d m=%0d got=%0d want=%0d", n, m, mine_wr, exp_mines);
    end
    total++;
    if (err !== !valid) begin
      bad++; $display("FAIL err n=%0d m=%0d got=%0b want=%0b", n, m, err, !valid);
    end
    total++;
    if (placed_ctr !== 8'(exp_mines)) begin
      bad++; $display("FAIL placed_ctr n=%0d got=%0d want=%0d", n, placed_ctr, exp_mines);
    end
    total++;
    if (viol !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL write_rules n=%0d got=viol%0d/busy%0b want=0/0", n, viol, busy);
    end
    if (!valid) begin
      total++;
      if (done_cyc - start_cyc > 1) begin
        bad++; $display("FAIL err_latency got=%0d want<=1", done_cyc - start_cyc);
      end
    end
  endtask

  task automatic test_lfsr(input int gap);
    bit ok;
    logic [15:0] v;
    logic [7:0]  exp;
    int sr, sc;
    repeat (gap) @(negedge clk);
    sr = $urandom_range(0, 15);
    sc = $urandom_range(0, 15);
    pulse_start(16, 1, sr, sc);
    wait_done(2000, ok);
    // Board is cleared for 256 cycles; then one candidate every GEN/CHECK pair.
    v = lfsr_acc;
    for (int k = 0; k < 256; k++) v = lfsr_step(v);
    while ({v[3:0], v[7:4]} == {4'(sr), 4'(sc)}) v = lfsr_step(lfsr_step(v));
    exp = {v[3:0], v[7:4]};
    total++;
    if (!ok || first_mine !== exp || mine_wr !== 1) begin
      bad++;
      $display("FAIL lfsr_mine gap=%0d got=%h/%0d want=%h/1", gap, first_mine, mine_wr, exp);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    pulse_start(5, 6, 2, 2);
    repeat (8) @(negedge clk);
    row_col_num = 5'd3; mine_num = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5000, ok);
    repeat (20) @(negedge clk);
    total++;
    if (!ok || done_cnt !== 1 || clr_wr !== 25 || mine_wr !== 6 || placed_ctr !== 8'd6 ||
        viol !== 0) begin
      bad++;
      $display("FAIL back_to_back got=d%0d c%0d m%0d p%0d v%0d want=d1 c25 m6 p6 v0",
               done_cnt, clr_wr, mine_wr, placed_ctr, viol);
    end
  endtask

  task automatic test_reset_mid_run;
    int k;
    pulse_start(9, 10, 4, 4);
    k = 0;
    while (clr_wr < 81 && k < 500) begin
      @(posedge clk);
      k++;
    end
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({wr_en, wr_row, wr_col, wr_mine, busy, done, err, placed_ctr} !== 23'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0",
               {wr_en, wr_row, wr_col, wr_mine, busy, done, err, placed_ctr});
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_cnt !== 0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_no_done got=%0d want=0", done_cnt);
    end
    rst = 1'b1;
    test_board(9, 10, 4, 4, 5000);
  endtask

  task automatic test_random(input int runs);
    int n, m;
    for (int i = 0; i < runs; i++) begin
      n = $urandom_range(0, 17);
      if (n >= 1 && n <= 16) m = $urandom_range(0, (n * n > 255) ? 255 : n * n);
      else m = $urandom_range(0, 255);
      repeat ($urandom_range(0, 7)) @(negedge clk);
      test_board(n, m, $urandom_range(0, 15), $urandom_range(0, 15), 30000);
    end
  endtask

  initial begin
    test_reset();
    test_board(9, 10, 4, 4, 5000);
    test_board(16, 255, 0, 0, 60000);
    test_board(8, 64, 0, 0, 10);
    test_board(0, 3, 0, 0, 10);
    test_board(17, 1, 0, 0, 10);
    test_board(4, 0, 1, 1, 200);
    test_board(16, 3, 15, 15, 2000);
    test_lfsr(0);
    test_lfsr(3);
    test_back_to_back();
    test_reset_mid_run();
    test_random(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
MINE_PLACER -- requirements
Module: mine_placer

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, meaning LFSR value loaded at reset; it SHALL be nonzero.
REQ-002 Parameter MAX_DIM, default 16, meaning maximum board rows/columns; it SHALL be fixed at 16.
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to generate a new board.
REQ-006 row_col_num  input  5  board dimension N (N×N fields); it SHALL be sampled on an accepted start.
REQ-007 mine_num  input  8  number of mines to place; it SHALL be sampled on an accepted start.
REQ-008 safe_row, safe_col  input  4 each  field that SHALL never receive a mine (the first-click field); sampled on an accepted start.
REQ-009 wr_en  output  1  board-memory write strobe.
REQ-010 wr_row, wr_col  output  4 each  board-memory write address.
REQ-011 wr_mine  output  1  mine bit written with wr_en.
REQ-012 busy  output  1  generation in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  settings rejected; held until the next accepted start.
REQ-015 placed_ctr  output  8  mines placed so far in the current run.

Function
REQ-016 States SHALL be IDLE, CLEAR, GEN, CHECK, WRITE, FIN.
REQ-017 start SHALL be accepted only in IDLE; start while busy=1 SHALL be ignored.
REQ-018 The accept cycle SHALL latch the inputs, set busy=1 on the next cycle, and clear err and placed_ctr.
REQ-019 Settings are invalid if N==0, N>16, or mine_num > N*N-1.
REQ-020 On invalid settings, IDLE SHALL go directly to FIN with err=1 and issue no writes.
REQ-021 In CLEAR the block SHALL emit exactly N*N writes with wr_mine=0, one per cycle, in row-major order from (0,0) to (N-1,N-1).
REQ-022 CLEAR SHALL also zero an internal 16×16 occupancy bitmap.
REQ-023 After the last CLEAR write: if mine_num==0, go to FIN; otherwise go to GEN.
REQ-024 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle in every state, so the result depends on the start time.
REQ-025 GEN SHALL form a candidate with row=lfsr[3:0] and col=lfsr[7:4], then go to CHECK.
REQ-026 CHECK SHALL reject the candidate, returning to GEN, if row>=N, col>=N, the bitmap bit is set, or the candidate equals (safe_row, safe_col); otherwise it SHALL go to WRITE.
REQ-027 WRITE SHALL assert wr_en for one cycle with wr_mine=1 at the candidate, set the bitmap bit, and increment placed_ctr.
REQ-028 After WRITE: if placed_ctr reaches mine_num, go to FIN; otherwise go to GEN.
REQ-029 FIN SHALL pulse done for one cycle, drop busy on the same cycle, and return to IDLE.
REQ-030 wr_en SHALL be asserted only in CLEAR and WRITE.
REQ-031 No field SHALL be written with wr_mine=1 more than once per run.
REQ-032 placed_ctr SHALL hold its final value in IDLE until the next accepted start.
REQ-033 Candidate comparisons SHALL use 5-bit arithmetic against N so that N=16 accepts row/col 15.

Reset
REQ-034 While rst=0, all outputs SHALL be 0, state SHALL be IDLE, the LFSR SHALL equal LFSR_SEED, and the bitmap SHALL be cleared.
REQ-035 Reset asserted mid-run SHALL abort immediately with no done pulse; partially written memory is the consumer's responsibility.
REQ-036 After reset release, the first start SHALL be accepted with no extra wait cycles.

Verification
REQ-037 N=9, mine_num=10, safe (4,4): exactly 81 zero-writes, then exactly 10 one-writes at distinct in-range fields, none at (4,4); done once; placed_ctr=10.
REQ-038 N=16, mine_num=255, safe (0,0): every field except (0,0) receives a mine, and the run terminates; done pulses once.
REQ-039 N=8, mine_num=64 -> err=1 and done pulse within 2 cycles of start, zero writes; N=0 -> same.
REQ-040 N=4, mine_num=0 -> 16 zero-writes, then done; placed_ctr=0; no wr_mine=1.
REQ-041 Second start pulsed while busy -> ignored: write count and done count match a single run.
REQ-042 rst driven low during GEN of a N=9/10 run -> outputs go to 0 asynchronously with no done; a following start runs a full, correct generation.
